// File: rtl/adc_sar_pkg.sv
// Shared encodings and defaults for the SAR ADC sequencer.
package adc_sar_pkg;

  localparam int ADC_BITS         = 10;
  localparam int SAMP_CYCLES_DEF  = 2;
  localparam int CONV_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  // A healthy SAR drives each B/BN pair to opposite values; any equal pair is a bad code.
  function automatic logic code_bad(input logic [ADC_BITS-1:0] b,
                                    input logic [ADC_BITS-1:0] bn);
    return |(~(b ^ bn));
  endfunction

endpackage

// File: rtl/adc_sar_result_buf.sv
// Single-entry result register with valid/ready handshake and sticky overrun.
module adc_sar_result_buf
  import adc_sar_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cap,
  input  logic [ADC_BITS-1:0] din,
  input  logic                data_ready,
  input  logic                err_clr,
  output logic [ADC_BITS-1:0] data,
  output logic                data_valid,
  output logic                overrun
);

  // An unconsumed result is lost only if the consumer is not taking it on the capture edge.
  logic ovr_set;
  assign ovr_set = cap && data_valid && !data_ready;

  // Load on capture, drop valid on handshake; overrun set beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (cap) begin
        data       <= din;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      overrun <= ovr_set || (overrun && !err_clr);
    end
  end

endmodule

// File: rtl/adc_sar_sequencer.sv
// Sample/convert/capture sequencer for an external SAR ADC core.
module adc_sar_sequencer
  import adc_sar_pkg::*;
#(
  parameter int SAMP_CYCLES  = SAMP_CYCLES_DEF,
  parameter int CONV_TIMEOUT = CONV_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cont_en,
  input  logic                err_clr,
  output logic                adc_samp,
  input  logic                adc_eoc,
  input  logic [ADC_BITS-1:0] adc_b,
  input  logic [ADC_BITS-1:0] adc_bn,
  output logic [ADC_BITS-1:0] data,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err,
  output logic                code_err
);

  localparam logic [3:0] SAMP_LAST = 4'(SAMP_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST = 8'(CONV_TIMEOUT - 1);

  state_t     state;
  logic [3:0] samp_cnt;
  logic [7:0] wait_cnt;
  logic       cap;

  assign busy = (state != S_IDLE);
  assign cap  = (state == S_CAPTURE);

  // Conversion FSM; adc_samp and the sticky flags are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      samp_cnt    <= '0;
      wait_cnt    <= '0;
      adc_samp    <= 1'b0;
      timeout_err <= 1'b0;
      code_err    <= 1'b0;
    end else begin
      // Clear first so a set below on the same edge takes priority.
      if (err_clr) begin
        timeout_err <= 1'b0;
        code_err    <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (start || cont_en) begin
            state    <= S_SAMPLE;
            samp_cnt <= '0;
            adc_samp <= 1'b1;
          end
        end
        S_SAMPLE: begin
          if (samp_cnt == SAMP_LAST) begin
            state    <= S_CONVERT;
            samp_cnt <= '0;
            wait_cnt <= '0;
            adc_samp <= 1'b0;
          end else begin
            samp_cnt <= samp_cnt + 4'd1;
          end
        end
        S_CONVERT: begin
          if (adc_eoc) begin
            state    <= S_CAPTURE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_CAPTURE: begin
          if (code_bad(adc_b, adc_bn)) code_err <= 1'b1;
          if (cont_en) begin
            state    <= S_SAMPLE;
            samp_cnt <= '0;
            adc_samp <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  adc_sar_result_buf u_rbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap        (cap),
    .din        (adc_b),
    .data_ready (data_ready),
    .err_clr    (err_clr),
    .data       (data),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Directed bench for adc_sar_sequencer with a behavioural nominal SAR core.
module tb_adc_sar_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cont_en;
  logic       err_clr;
  logic       adc_samp;
  bit         adc_eoc;
  logic [9:0] adc_b;
  logic [9:0] adc_bn;
  logic [9:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       overrun;
  logic       timeout_err;
  logic       code_err;

  int checks = 0;
  int errors = 0;
  int samp_rises = 0;
  int rise_base;
  bit eoc_mode;

  adc_sar_sequencer #(.SAMP_CYCLES(2), .CONV_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cont_en     (cont_en),
    .err_clr     (err_clr),
    .adc_samp    (adc_samp),
    .adc_eoc     (adc_eoc),
    .adc_b       (adc_b),
    .adc_bn      (adc_bn),
    .data        (data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .code_err    (code_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Nominal SAR: eoc is seen by the sequencer on the 11th clock edge after adc_samp falls.
  always @(negedge adc_samp) begin
    if (eoc_mode) begin
      repeat (10) @(posedge clk);
      #1 adc_eoc = 1'b1;
      @(posedge clk);
      #1 adc_eoc = 1'b0;
    end
  end

  always @(posedge adc_samp) samp_rises++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cont_en = 1'b0; err_clr = 1'b0;
    data_ready = 1'b0; adc_b = '0; adc_bn = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_samp",  32'(adc_samp),    32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_data",  32'(data),        32'd0);
    chk("rst_valid", 32'(data_valid),  32'd0);
    chk("rst_flags", {29'd0, overrun, timeout_err, code_err}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_samp", 32'(adc_samp), 32'd0);

    // Single shot: latency SAMP_CYCLES+12 = 14 edges from the start edge.
    eoc_mode = 1'b1; adc_b = 10'h2A5; adc_bn = 10'h15A;
    start = 1'b1; tick(1); start = 1'b0;
    chk("ss_samp_e0", 32'(adc_samp), 32'd1);
    chk("ss_busy_e0", 32'(busy),     32'd1);
    tick(1);
    chk("ss_samp_e1", 32'(adc_samp), 32'd1);
    tick(1);
    chk("ss_samp_e2", 32'(adc_samp), 32'd0);
    tick(11);
    chk("ss_valid_e13", 32'(data_valid), 32'd0);
    tick(1);
    chk("ss_valid_e14", 32'(data_valid), 32'd1);
    chk("ss_data",      32'(data),       32'h2A5);
    chk("ss_flags", {29'd0, overrun, timeout_err, code_err}, 32'd0);
    chk("ss_idle",      32'(busy),       32'd0);
    data_ready = 1'b1; tick(1); data_ready = 1'b0;
    chk("ss_consumed",  32'(data_valid), 32'd0);

    // Timeout: no eoc, flag rises after 2+16 edges.
    eoc_mode = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    tick(17);
    chk("to_e17",      32'(timeout_err), 32'd0);
    chk("to_busy_e17", 32'(busy),        32'd1);
    tick(1);
    chk("to_e18",      32'(timeout_err), 32'd1);
    chk("to_idle",     32'(busy),        32'd0);
    chk("to_novalid",  32'(data_valid),  32'd0);
    tick(3);
    chk("to_sticky",   32'(timeout_err), 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("to_clr",      32'(timeout_err), 32'd0);

    // Code error: bit 0 pair equal.
    eoc_mode = 1'b1; adc_b = 10'h3FF; adc_bn = 10'h001;
    start = 1'b1; tick(1); start = 1'b0;
    tick(14);
    chk("ce_data", 32'(data),     32'h3FF);
    chk("ce_flag", 32'(code_err), 32'd1);
    err_clr = 1'b1; data_ready = 1'b1; tick(1); err_clr = 1'b0; data_ready = 1'b0;
    chk("ce_clr",   32'(code_err),   32'd0);
    chk("ce_cons",  32'(data_valid), 32'd0);

    // Continuous, consumer stalled: second capture overruns.
    adc_b = 10'h155; adc_bn = 10'h2AA;
    cont_en = 1'b1; tick(1);
    tick(14);
    chk("cm_data1", 32'(data),     32'h155);
    chk("cm_ovr1",  32'(overrun),  32'd0);
    chk("cm_resamp", 32'(adc_samp), 32'd1);
    adc_b = 10'h0F0; adc_bn = 10'h30F;
    cont_en = 1'b0;
    tick(14);
    chk("cm_data2", 32'(data),       32'h0F0);
    chk("cm_ovr2",  32'(overrun),    32'd1);
    chk("cm_valid", 32'(data_valid), 32'd1);
    chk("cm_stop",  32'(busy),       32'd0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("cm_ovr_clr", 32'(overrun),    32'd0);
    chk("cm_keep",    32'(data_valid), 32'd1);

    // Continuous, capture coincides with data_ready: no overrun.
    adc_b = 10'h111; adc_bn = 10'h2EE;
    cont_en = 1'b1; tick(1);
    tick(13);
    data_ready = 1'b1; tick(1);
    chk("cr_data1",  32'(data),       32'h111);
    chk("cr_valid1", 32'(data_valid), 32'd1);
    chk("cr_ovr1",   32'(overrun),    32'd0);
    adc_b = 10'h222; adc_bn = 10'h1DD; cont_en = 1'b0;
    tick(1);
    chk("cr_cons", 32'(data_valid), 32'd0);
    tick(13);
    chk("cr_data2",  32'(data),       32'h222);
    chk("cr_valid2", 32'(data_valid), 32'd1);
    chk("cr_ovr2",   32'(overrun),    32'd0);
    data_ready = 1'b0;
    tick(2);

    // Reset in CONVERT aborts; data register clears immediately.
    adc_b = 10'h2A5; adc_bn = 10'h15A;
    start = 1'b1; tick(1); start = 1'b0;
    tick(4);
    chk("ra_inconv", 32'(busy), 32'd1);
    rst_n = 1'b0; #1;
    chk("ra_samp",  32'(adc_samp),   32'd0);
    chk("ra_valid", 32'(data_valid), 32'd0);
    chk("ra_data",  32'(data),       32'd0);
    chk("ra_busy",  32'(busy),       32'd0);
    tick(2); rst_n = 1'b1;
    tick(20);
    chk("ra_nocap", 32'(data_valid), 32'd0);
    start = 1'b1; tick(1); start = 1'b0;
    tick(14);
    chk("ra_data2",  32'(data),       32'h2A5);
    chk("ra_valid2", 32'(data_valid), 32'd1);

    // start held high: one conversion per IDLE visit.
    data_ready = 1'b1;
    rise_base = samp_rises;
    start = 1'b1; tick(1);
    tick(14);
    chk("sh_rises1", 32'(samp_rises - rise_base), 32'd1);
    chk("sh_idle",   32'(busy),                   32'd0);
    tick(1);
    chk("sh_restart", 32'(busy),                   32'd1);
    chk("sh_rises2",  32'(samp_rises - rise_base), 32'd2);
    start = 1'b0;
    tick(14);
    chk("sh_done",    32'(busy),                   32'd0);
    chk("sh_rises3",  32'(samp_rises - rise_base), 32'd2);
    data_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
